// File: rtl/decode_queue.sv
`default_nettype none
// ============================================================================
//  Module   : decode_queue
//  Brief    : Elastic valid/ready queue between decode and rename. Holds up
//             to DEPTH payloads with full push+pop throughput, a synchronous
//             flush for branch mispredict, an occupancy count and an
//             almost-full early-stall hint for fetch.
//  Revision : 1.0 - initial release, successor to the single-entry skid buffer
// ============================================================================
module decode_queue #(
    parameter int DATA_W   = 128,
    parameter int DEPTH    = 8,
    parameter int AFULL_TH = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       valid_in,
    output logic                       ready_in,
    input  logic [DATA_W-1:0]          data_in,
    output logic                       valid_out,
    input  logic                       ready_out,
    output logic [DATA_W-1:0]          data_out,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       almost_full,
    output logic                       empty
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_AFULL_CNT = c_CNT_W'(AFULL_TH);

    // Storage is deliberately left out of reset; validity is tracked by count.
    logic [DATA_W-1:0]  mem_q [DEPTH];

    logic [c_PTR_W-1:0] head_q, head_d;
    logic [c_PTR_W-1:0] tail_q, tail_d;
    logic [c_CNT_W-1:0] count_q, count_d;

    logic               w_push;
    logic               w_pop;

    // Status outputs depend only on registered state, so neither handshake
    // side sees a combinational path from the other side.
    assign ready_in    = (count_q != c_DEPTH_CNT);
    assign valid_out   = (count_q != '0);
    assign empty       = (count_q == '0);
    assign almost_full = (count_q >= c_AFULL_CNT);
    assign count       = count_q;
    assign data_out    = mem_q[head_q];

    // Flush wins: a push or pop requested in the flush cycle is dropped.
    assign w_push = valid_in  & ready_in  & ~flush;
    assign w_pop  = valid_out & ready_out & ~flush;

    // Next-state for pointers and occupancy; pointers wrap naturally since
    // DEPTH is a power of two.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (w_push) begin
                tail_d = tail_q + c_PTR_W'(1);
            end
            if (w_pop) begin
                head_d = head_q + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + c_CNT_W'(1);
                2'b01:   count_d = count_q - c_CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state, cleared asynchronously so the queue empties immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload write at the tail on an accepted push.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[tail_q] <= data_in;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decode_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decode_queue
//  Brief    : Self-checking bench for decode_queue: queue-based reference
//             model compared every cycle, directed scenarios with literal
//             expectations, then randomized traffic with occasional flush.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_decode_queue;

    localparam int DATA_W   = 128;
    localparam int DEPTH    = 8;
    localparam int AFULL_TH = 6;
    localparam int CNT_W    = $clog2(DEPTH) + 1;

    logic              clk;
    logic              reset;
    logic              flush;
    logic              valid_in;
    logic              ready_in;
    logic [DATA_W-1:0] data_in;
    logic              valid_out;
    logic              ready_out;
    logic [DATA_W-1:0] data_out;
    logic [CNT_W-1:0]  count;
    logic              almost_full;
    logic              empty;

    int tests = 0;
    int fails = 0;
    bit check_en = 0;

    logic [DATA_W-1:0] mq[$];
    bit m_push, m_pop;

    decode_queue #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .AFULL_TH (AFULL_TH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .valid_in    (valid_in),
        .ready_in    (ready_in),
        .data_in     (data_in),
        .valid_out   (valid_out),
        .ready_out   (ready_out),
        .data_out    (data_out),
        .count       (count),
        .almost_full (almost_full),
        .empty       (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an ordered list of held payloads.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
        end else if (flush) begin
            mq.delete();
        end else begin
            m_pop  = ready_out && (mq.size() != 0);
            m_push = valid_in && (mq.size() != DEPTH);
            if (m_pop)  void'(mq.pop_front());
            if (m_push) mq.push_back(data_in);
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            chk("m_valid_out",   valid_out,   (mq.size() != 0));
            chk("m_ready_in",    ready_in,    (mq.size() != DEPTH));
            chk("m_count",       count,       mq.size());
            chk("m_empty",       empty,       (mq.size() == 0));
            chk("m_almost_full", almost_full, (mq.size() >= AFULL_TH));
            if (mq.size() != 0) chk("m_data_out", data_out, mq[0]);
        end
    end

    // One cycle of stimulus; returns 1 time unit after the edge that used it.
    task automatic drive(input logic vi, input logic [DATA_W-1:0] d,
                         input logic ro, input logic fl);
        valid_in  = vi;
        data_in   = d;
        ready_out = ro;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 2 * DEPTH && valid_out; k++) drive(1'b0, '0, 1'b1, 1'b0);
        chk("drain_empty", empty, 1'b1);
    endtask

    logic [DATA_W-1:0] rd;

    initial begin
        reset = 1'b1; flush = 1'b0; valid_in = 1'b0; ready_out = 1'b0; data_in = '0;
        @(posedge clk); #1;
        check_en = 1;
        chk("rst_count", count, 0);
        chk("rst_valid_out", valid_out, 0);
        chk("rst_ready_in", ready_in, 1);
        chk("rst_empty", empty, 1);
        chk("rst_afull", almost_full, 0);
        reset = 1'b0;

        // 1: pass-through of A,B,C with ready_out high
        drive(1, 128'hA, 1, 0);
        chk("t1_a", data_out, 128'hA); chk("t1_cnt_a", count, 1);
        drive(1, 128'hB, 1, 0);
        chk("t1_b", data_out, 128'hB); chk("t1_cnt_b", count, 1);
        drive(1, 128'hC, 1, 0);
        chk("t1_c", data_out, 128'hC); chk("t1_vo_c", valid_out, 1);
        drive(0, '0, 1, 0);
        chk("t1_cnt_end", count, 0); chk("t1_vo_end", valid_out, 0);

        // 2: fill to DEPTH, refuse extra push, drain in order
        for (int i = 1; i <= DEPTH; i++) begin
            drive(1, DATA_W'(i), 0, 0);
            chk("t2_afull", almost_full, (i >= AFULL_TH));
        end
        chk("t2_full_ready", ready_in, 0); chk("t2_full_cnt", count, DEPTH);
        drive(1, 128'h9, 0, 0);
        chk("t2_refused_cnt", count, DEPTH);
        for (int i = 1; i <= DEPTH; i++) begin
            chk("t2_order", data_out, DATA_W'(i));
            drive(0, '0, 1, 0);
        end
        chk("t2_drained", count, 0);

        // 3: steady push+pop across pointer wrap
        drive(1, 128'h0, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            chk("t3_seq", data_out, DATA_W'(i - 1));
            chk("t3_cnt", count, 1);
            drive(1, DATA_W'(i), 1, 0);
        end
        drain();

        // 4: flush at count 5 with push and pop requested
        for (int i = 0; i < 5; i++) drive(1, DATA_W'(8'h40 + i), 0, 0);
        chk("t4_pre_cnt", count, 5);
        drive(1, 128'hDEAD, 1, 1);
        chk("t4_cnt", count, 0); chk("t4_vo", valid_out, 0); chk("t4_ri", ready_in, 1);
        drive(1, 128'hAA, 1, 0);
        chk("t4_first", data_out, 128'hAA); chk("t4_cnt1", count, 1);
        drain();

        // 5: full queue with simultaneous pop refuses the push
        for (int i = 0; i < DEPTH; i++) drive(1, DATA_W'(8'h10 + i), 0, 0);
        chk("t5_ri_full", ready_in, 0);
        drive(1, 128'h77, 1, 0);
        chk("t5_cnt7", count, DEPTH - 1); chk("t5_head", data_out, 128'h11);
        drive(1, 128'h77, 1, 0);
        chk("t5_cnt_stay", count, DEPTH - 1); chk("t5_head2", data_out, 128'h12);
        drain();

        // 6: asynchronous reset mid-cycle with count 4
        for (int i = 0; i < 4; i++) drive(1, DATA_W'(8'h60 + i), 0, 0);
        valid_in = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("t6_cnt", count, 0); chk("t6_vo", valid_out, 0); chk("t6_empty", empty, 1);
        #2 reset = 1'b0;
        @(posedge clk); #1;
        drive(1, 128'h55, 1, 0);
        chk("t6_first", data_out, 128'h55); chk("t6_cnt1", count, 1);
        drain();

        // Randomized traffic with occasional flush; data held while stalled.
        rd = '0;
        for (int n = 0; n < 3000; n++) begin
            if (!(valid_in && !ready_in)) begin
                rd = {$urandom, $urandom, $urandom, $urandom};
                valid_in = ($urandom_range(0, 3) != 0);
            end
            drive(valid_in, rd, ($urandom_range(0, 2) != 0), ($urandom_range(0, 63) == 0));
        end

        drive(0, '0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
